// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
// Collects single-cycle press pulses from N_BTN debouncers, keeps at most one
// pending event per button, and round-robin presents them on a valid/ready
// event port. A press on a button that is already pending (and not being
// granted on that edge) is dropped and flagged in a sticky overflow bit.
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-low reset
//   i_btn_pulse  [N_BTN]  one-cycle press pulses
//   o_evt_valid           event presented on o_evt_id
//   i_evt_ready           consumer accepts when o_evt_valid & i_evt_ready
//   o_evt_id     [IDX_W]  button index of the presented event
//   o_pending    [N_BTN]  queued, not-yet-presented events
//   o_overflow   [N_BTN]  sticky dropped-press flags
//   i_ovf_clr             synchronous clear of all overflow bits
// -----------------------------------------------------------------------------
module button_event_arbiter #(
    parameter int unsigned N_BTN = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn_pulse,
    output logic             o_evt_valid,
    input  logic             i_evt_ready,
    output logic [IDX_W-1:0] o_evt_id,
    output logic [N_BTN-1:0] o_pending,
    output logic [N_BTN-1:0] o_overflow,
    input  logic             i_ovf_clr
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0]       r_state;
    logic             r_evt_valid;
    logic [IDX_W-1:0] r_evt_id;
    logic [IDX_W-1:0] r_last_grant;
    logic [N_BTN-1:0] r_pending;
    logic [N_BTN-1:0] r_overflow;

    logic [0:0]       w_nxt_state;
    logic             w_nxt_valid;
    logic [IDX_W-1:0] w_nxt_id;
    logic [IDX_W-1:0] w_nxt_last;
    logic [N_BTN-1:0] w_nxt_pending;
    logic [N_BTN-1:0] w_nxt_overflow;
    logic             w_grant;
    logic [IDX_W-1:0] w_sel;
    logic             w_any;
    logic [N_BTN-1:0] w_gnt_mask;

    // Round-robin pick: first registered pending bit after r_last_grant, wrapping.
    always_comb begin : rr_select
        logic [IDX_W-1:0] v_idx;
        w_sel = '0;
        w_any = 1'b0;
        v_idx = r_last_grant;
        for (int k = 0; k < N_BTN; k++) begin
            v_idx = (v_idx == IDX_W'(N_BTN - 1)) ? '0 : v_idx + IDX_W'(1);
            if (!w_any && r_pending[v_idx]) begin
                w_sel = v_idx;
                w_any = 1'b1;
            end
        end
    end

    // Next-state and next-output logic for the presentation FSM.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_valid = r_evt_valid;
        w_nxt_id    = r_evt_id;
        w_nxt_last  = r_last_grant;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_nxt_valid = 1'b1;
                    w_nxt_id    = w_sel;
                    w_nxt_last  = w_sel;
                    w_nxt_state = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_evt_ready) begin
                    if (w_any) begin
                        // Back-to-back: load the next winner on the accepting edge.
                        w_grant     = 1'b1;
                        w_nxt_id    = w_sel;
                        w_nxt_last  = w_sel;
                    end else begin
                        w_nxt_valid = 1'b0;
                        w_nxt_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_nxt_valid = 1'b0;
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Pending/overflow update; a pulse on the granted button re-queues it.
    always_comb begin
        w_gnt_mask     = w_grant ? (N_BTN'(1) << w_sel) : '0;
        w_nxt_pending  = (r_pending & ~w_gnt_mask) | i_btn_pulse;
        // Set beats clear on the same edge.
        w_nxt_overflow = (i_ovf_clr ? '0 : r_overflow)
                       | (i_btn_pulse & r_pending & ~w_gnt_mask);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_evt_valid  <= 1'b0;
            r_evt_id     <= '0;
            r_last_grant <= IDX_W'(N_BTN - 1);
            r_pending    <= '0;
            r_overflow   <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_evt_valid  <= w_nxt_valid;
            r_evt_id     <= w_nxt_id;
            r_last_grant <= w_nxt_last;
            r_pending    <= w_nxt_pending;
            r_overflow   <= w_nxt_overflow;
        end
    end

    assign o_evt_valid = r_evt_valid;
    assign o_evt_id    = r_evt_id;
    assign o_pending   = r_pending;
    assign o_overflow  = r_overflow;

endmodule
